// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 Hz VGA timing, pixel request and video gating (optional VGA_BORDER_EN white frame).
// Latency: pix_x/pix_y combinational from counters; sync/valid/frame_start registered 1 clk, rgb follows pix_data.
// Backpressure: none; free-running raster, the pattern source must answer every request one clock later.
module vga_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_VALID  = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter int SYNC_POL = 0
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
    localparam logic [9:0] H_BEG   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [9:0] V_BEG   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VALID - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       in_win;
    logic       hsync_d, vsync_d, active_d, fs_d;
    logic       hsync_q, vsync_q, active_q, fs_q;

    // Raster counters: horizontal wraps every line, vertical advances on the last pixel of a line.
    always_comb begin
        cnt_h_d = (cnt_h_q == H_LAST) ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == H_LAST) begin
            cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
        end
    end

    // Counter state; reset restarts the raster at the top-left of the sync region.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q <= 10'd0;
            cnt_v_q <= 10'd0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Pixel request and decode of the current raster position.
    always_comb begin
        in_win   = (cnt_h_q >= H_BEG) && (cnt_h_q <= H_END) &&
                   (cnt_v_q >= V_BEG) && (cnt_v_q <= V_END);
        pix_x    = in_win ? (cnt_h_q - H_BEG) : 10'h3FF;
        pix_y    = in_win ? (cnt_v_q - V_BEG) : 10'h3FF;
        hsync_d  = (cnt_h_q < H_SYNC_W);
        vsync_d  = (cnt_v_q < V_SYNC_W);
        active_d = in_win;
        fs_d     = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
    end

    // Decode stage delayed by one clock so syncs line up with the returned pix_data.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            fs_q     <= fs_d;
        end
    end

    assign hsync       = hsync_q ? SYNC_ACT : ~SYNC_ACT;
    assign vsync       = vsync_q ? SYNC_ACT : ~SYNC_ACT;
    assign rgb_valid   = active_q;
    assign frame_start = fs_q;

`ifdef VGA_BORDER_EN
    logic [9:0] pix_x_q, pix_y_q;
    logic       on_edge;

    // Coordinates of the pixel whose data is arriving now, for the border test.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_x_q <= 10'h3FF;
            pix_y_q <= 10'h3FF;
        end else begin
            pix_x_q <= pix_x;
            pix_y_q <= pix_y;
        end
    end

    // White outline on the outermost active pixels replaces the pattern there.
    always_comb begin
        on_edge = (pix_x_q == 10'd0) || (pix_x_q == 10'(H_VALID - 1)) ||
                  (pix_y_q == 10'd0) || (pix_y_q == 10'(V_VALID - 1));
        rgb     = 16'h0000;
        if (active_q) begin
            rgb = on_edge ? 16'hFFFF : pix_data;
        end
    end
`else
    // Blank video outside the active window.
    always_comb begin
        rgb = active_q ? pix_data : 16'h0000;
    end
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: full-size instance for line/sync/latency/reset checks,
// reduced-geometry instance for whole-frame period, pixel count and border checks.
module tb_vga_ctrl;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rst_s_n = 1'b0;
    logic        stub_force = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic [15:0] pix_data_s = 16'h0000;

    logic [9:0]  pix_x, pix_y, pix_x_s, pix_y_s;
    logic        hsync, vsync, rgb_valid, frame_start;
    logic        hsync_s, vsync_s, rgb_valid_s, frame_start_s;
    logic [15:0] rgb, rgb_s;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #20 vga_clk = ~vga_clk;

    // Pattern source stubs: echo the requested column, or a fixed word.
    always @(posedge vga_clk) pix_data   <= stub_force ? 16'hFFFF : {6'd0, pix_x};
    always @(posedge vga_clk) pix_data_s <= 16'h1234;

    vga_ctrl dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
        .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start)
    );

    // 17 x 9 raster: 8 x 4 active pixels, 153 clocks per frame.
    vga_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(1), .SYNC_POL(0)
    ) dut_s (
        .vga_clk(vga_clk), .sys_rst_n(rst_s_n), .pix_data(pix_data_s),
        .pix_x(pix_x_s), .pix_y(pix_y_s), .hsync(hsync_s), .vsync(vsync_s),
        .rgb_valid(rgb_valid_s), .rgb(rgb_s), .frame_start(frame_start_s)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [39:0] got, exp;
        #30;
        exp = {10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        got = {pix_x, pix_y, hsync, vsync, rgb_valid, frame_start, rgb};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_release();
        #20;
        sys_rst_n = 1'b1;
        cyc = 0;
        tick();
        n_cmp++;
        if ({frame_start, hsync, vsync, rgb_valid} !== 4'b1000) begin
            n_err++;
            $display("FAIL first_edge fs/hs/vs/vld got=%b exp=1000", {frame_start, hsync, vsync, rgb_valid});
        end
        tick();
        n_cmp++;
        if (frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL fs_one_clock got=%b exp=0", frame_start);
        end
    endtask

    task automatic test_sync_timing();
        int hs_low = 0, hs_last = 0, vs_low = 0, vs_last = 0, fs_cnt = 0;
        logic hs801 = 1'b1;
        // ticks 1 and 2 were consumed by test_release; both had hsync/vsync low
        hs_low = 2; hs_last = 2; vs_low = 2; vs_last = 2;
        while (cyc < 1700) begin
            tick();
            if (cyc <= 800 && hsync == 1'b0) begin hs_low++; hs_last = cyc; end
            if (vsync == 1'b0) begin vs_low++; vs_last = cyc; end
            if (frame_start) fs_cnt++;
            if (cyc == 801) hs801 = hsync;
        end
        n_cmp++;
        if (hs_low !== 96 || hs_last !== 96) begin
            n_err++;
            $display("FAIL hsync_width low=%0d last=%0d exp=96/96", hs_low, hs_last);
        end
        n_cmp++;
        if (hs801 !== 1'b0) begin
            n_err++;
            $display("FAIL line_period hsync@801 got=%b exp=0", hs801);
        end
        n_cmp++;
        if (vs_low !== 1600 || vs_last !== 1600) begin
            n_err++;
            $display("FAIL vsync_width low=%0d last=%0d exp=1600/1600", vs_low, vs_last);
        end
        n_cmp++;
        if (fs_cnt !== 0) begin
            n_err++;
            $display("FAIL fs_spurious got=%0d exp=0", fs_cnt);
        end
    endtask

    task automatic test_active_line();
        int vld_pre = 0, vld_line = 0, first_vld = 0;
        while (cyc < 28790) begin
            tick();
            if (rgb_valid && cyc <= 28144) vld_pre++;
            if (rgb_valid && cyc > 28144) begin
                vld_line++;
                if (first_vld == 0) first_vld = cyc;
            end
            if (cyc == 28144) begin
                n_cmp++;
                if ({pix_x, pix_y} !== {10'd0, 10'd0}) begin
                    n_err++;
                    $display("FAIL first_req x=%h y=%h exp=000/000", pix_x, pix_y);
                end
            end
            if (cyc == 28145) begin
                n_cmp++;
                if (rgb_valid !== 1'b1 || rgb !== 16'h0000) begin
                    n_err++;
                    $display("FAIL first_pix vld=%b rgb=%h exp=1/0000", rgb_valid, rgb);
                end
            end
            if (cyc == 28783) begin
                n_cmp++;
                if ({pix_x, pix_y} !== {10'd639, 10'd0}) begin
                    n_err++;
                    $display("FAIL last_req x=%0d y=%0d exp=639/0", pix_x, pix_y);
                end
            end
            if (cyc == 28784) begin
                n_cmp++;
                if (rgb_valid !== 1'b1 || rgb !== 16'h027F) begin
                    n_err++;
                    $display("FAIL last_pix vld=%b rgb=%h exp=1/027F", rgb_valid, rgb);
                end
            end
            if (cyc == 28785) begin
                n_cmp++;
                if (rgb_valid !== 1'b0 || rgb !== 16'h0000 || pix_x !== 10'h3FF) begin
                    n_err++;
                    $display("FAIL after_line vld=%b rgb=%h x=%h exp=0/0000/3FF", rgb_valid, rgb, pix_x);
                end
            end
        end
        n_cmp++;
        if (vld_pre !== 0 || vld_line !== 640 || first_vld !== 28145) begin
            n_err++;
            $display("FAIL line_valid pre=%0d run=%0d first=%0d exp=0/640/28145", vld_pre, vld_line, first_vld);
        end
    endtask

    task automatic test_outside();
        while (cyc < 28800) tick();
        stub_force = 1'b1;
        while (cyc < 28900) tick();
        n_cmp++;
        if ({pix_x, pix_y} !== {10'h3FF, 10'h3FF}) begin
            n_err++;
            $display("FAIL outside_req x=%h y=%h exp=3FF/3FF", pix_x, pix_y);
        end
        tick();
        n_cmp++;
        if (rgb_valid !== 1'b0 || rgb !== 16'h0000) begin
            n_err++;
            $display("FAIL outside_blank vld=%b rgb=%h exp=0/0000", rgb_valid, rgb);
        end
        while (cyc < 28945) tick();
        n_cmp++;
        if (rgb_valid !== 1'b1 || rgb !== 16'hFFFF) begin
            n_err++;
            $display("FAIL inside_pass vld=%b rgb=%h exp=1/FFFF", rgb_valid, rgb);
        end
        stub_force = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [39:0] got, exp;
        int fs_cnt = 0;
        while (cyc < 29200) tick();
        n_cmp++;
        if (rgb_valid !== 1'b1 || pix_x !== 10'd256 || pix_y !== 10'd1) begin
            n_err++;
            $display("FAIL pre_reset vld=%b x=%0d y=%0d exp=1/256/1", rgb_valid, pix_x, pix_y);
        end
        #5;
        sys_rst_n = 1'b0;
        #1;
        exp = {10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        got = {pix_x, pix_y, hsync, vsync, rgb_valid, frame_start, rgb};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=%h", got, exp);
        end
        #5;
        sys_rst_n = 1'b1;
        cyc = 0;
        tick();
        n_cmp++;
        if ({frame_start, hsync, vsync} !== 3'b100) begin
            n_err++;
            $display("FAIL restart_edge fs/hs/vs got=%b exp=100", {frame_start, hsync, vsync});
        end
        while (cyc < 1000) begin
            tick();
            if (frame_start) fs_cnt++;
        end
        n_cmp++;
        if (fs_cnt !== 0) begin
            n_err++;
            $display("FAIL restart_fs_extra got=%0d exp=0", fs_cnt);
        end
    endtask

    task automatic test_small_frame();
        int fs1 = 0, fs2 = 0, vld = 0, n_pat = 0, n_white = 0, hs_low = 0;
        int exp_pat, exp_white;
`ifdef VGA_BORDER_EN
        exp_pat = 12; exp_white = 20;
`else
        exp_pat = 32; exp_white = 0;
`endif
        #5;
        rst_s_n = 1'b1;
        cyc = 0;
        while (cyc < 320) begin
            tick();
            if (frame_start_s) begin
                if (fs1 == 0) fs1 = cyc;
                else if (fs2 == 0) fs2 = cyc;
            end
            if (cyc <= 153 && rgb_valid_s) begin
                vld++;
                if (rgb_s == 16'h1234) n_pat++;
                if (rgb_s == 16'hFFFF) n_white++;
            end
            if (cyc <= 17 && hsync_s == 1'b0) hs_low++;
        end
        n_cmp++;
        if (fs1 !== 1 || fs2 !== 154) begin
            n_err++;
            $display("FAIL frame_period first=%0d second=%0d exp=1/154", fs1, fs2);
        end
        n_cmp++;
        if (vld !== 32) begin
            n_err++;
            $display("FAIL frame_valid_count got=%0d exp=32", vld);
        end
        n_cmp++;
        if (n_pat !== exp_pat || n_white !== exp_white) begin
            n_err++;
            $display("FAIL border_pixels pat=%0d white=%0d exp=%0d/%0d", n_pat, n_white, exp_pat, exp_white);
        end
        n_cmp++;
        if (hs_low !== 4) begin
            n_err++;
            $display("FAIL small_hsync_width got=%0d exp=4", hs_low);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_sync_timing();
        test_active_line();
        test_outside();
        test_mid_reset();
        test_small_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
